// File: rtl/stdcore_pkg.sv
// stdcore_pkg: constants and helpers shared by the stdcore blocks.
package stdcore_pkg;
    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_OWN  = 1'b1;
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v >>= 1) r++;
        return r;
    endfunction
endpackage

// File: rtl/stdcore_rrarb_oreg.sv
// stdcore_rrarb_oreg: 2-entry skid slice registering data and id toward the consumer.
module stdcore_rrarb_oreg #(
    parameter int DW = 8,
    parameter int IDW = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [DW-1:0]  s_data_i,
    input  logic [IDW-1:0] s_id_i,
    input  logic           s_val_i,
    output logic           s_rdy_o,
    output logic [DW-1:0]  m_data_o,
    output logic [IDW-1:0] m_id_o,
    output logic           m_val_o,
    input  logic           m_rdy_i
);
    logic [DW+IDW-1:0] main_q, skid_q;
    logic main_val_q, skid_val_q;
    assign s_rdy_o = !skid_val_q;
    assign {m_id_o, m_data_o} = main_q;
    assign m_val_o = main_val_q;
    // The skid entry only fills while the main entry is stalled, so ready never depends on m_rdy_i.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_val_q <= 1'b0;
            skid_val_q <= 1'b0;
        end else if (skid_val_q) begin
            if (m_rdy_i) begin
                main_q     <= skid_q;
                skid_val_q <= 1'b0;
            end
        end else if (!main_val_q || m_rdy_i) begin
            main_q     <= {s_id_i, s_data_i};
            main_val_q <= s_val_i;
        end else if (s_val_i) begin
            skid_q     <= {s_id_i, s_data_i};
            skid_val_q <= 1'b1;
        end
    end
endmodule

// File: rtl/stdcore_rrarb.sv
// stdcore_rrarb: round-robin N:1 arbiter granting bursts of up to BURST beats.
// Define STDCORE_RRARB_OREG_EN to register c/c_val/c_id through a skid slice.
module stdcore_rrarb
    import stdcore_pkg::*;
#(
    parameter int N = 4,
    parameter int DW = 8,
    parameter int BURST = 4,
    localparam int IDW = clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N*DW-1:0] p,
    input  logic [N-1:0]    p_val,
    output logic [N-1:0]    p_rdy,
    output logic [DW-1:0]   c,
    output logic            c_val,
    input  logic            c_rdy,
    output logic [IDW-1:0]  c_id
);
    logic state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d, cur_q, cur_d, w, owner;
    logic [7:0] cnt_q, cnt_d;
    logic [DW-1:0] c_arb;
    logic a_val, a_rdy, acc, last;

    function automatic logic [IDW-1:0] inc(input logic [IDW-1:0] x);
        return (int'(x) == N - 1) ? '0 : x + 1'b1;
    endfunction

    // Scan downward so the port closest to ptr overwrites the others.
    always_comb begin
        w = ptr_q;
        for (int i = N - 1; i >= 0; i--)
            if (p_val[(int'(ptr_q) + i) % N]) w = IDW'((int'(ptr_q) + i) % N);
    end

    assign owner = (state_q == ST_OWN) ? cur_q : w;
    assign a_val = !rst && ((state_q == ST_OWN) ? p_val[cur_q] : |p_val);
    assign p_rdy = rst ? '0 : N'(a_rdy) << owner;
    assign c_arb = p[owner*DW +: DW];
    assign acc   = a_val && a_rdy;
    assign last  = 9'(cnt_q) + 9'd1 == 9'(BURST);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cur_d   = cur_q;
        cnt_d   = cnt_q;
        if (state_q == ST_IDLE) begin
            if (|p_val) begin
                if (BURST == 1 && acc) ptr_d = inc(w);
                else begin
                    state_d = ST_OWN;
                    cur_d   = w;
                    cnt_d   = {7'd0, acc};
                end
            end
        end else if (!p_val[cur_q] || (acc && last)) begin
            state_d = ST_IDLE;
            ptr_d   = inc(cur_q);
        end else if (acc) cnt_d = cnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            cur_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cur_q   <= cur_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef STDCORE_RRARB_OREG_EN
    logic o_val;
    stdcore_rrarb_oreg #(.DW(DW), .IDW(IDW)) u_oreg (
        .clk(clk), .rst(rst),
        .s_data_i(c_arb), .s_id_i(owner), .s_val_i(a_val), .s_rdy_o(a_rdy),
        .m_data_o(c), .m_id_o(c_id), .m_val_o(o_val), .m_rdy_i(c_rdy)
    );
    assign c_val = o_val && !rst;
`else
    assign a_rdy = c_rdy;
    assign c     = c_arb;
    assign c_id  = owner;
    assign c_val = a_val;
`endif
endmodule

// File: tb/tb_stdcore_rrarb.sv
// tb_stdcore_rrarb: directed scenarios plus randomized traffic against a reference model.
module tb_stdcore_rrarb;
    localparam int N = 4, DW = 8, B = 4;
    logic clk = 1'b0, rst = 1'b1, c_rdy = 1'b0;
    logic [N*DW-1:0] p = '0;
    logic [N-1:0] p_val = '0, p_rdy, p_rdy1;
    logic [DW-1:0] c, c1;
    logic c_val, c_val1;
    logic [1:0] c_id, c_id1;
    int n_chk = 0, n_fail = 0;
    int holder, taken, nxt;
    int sent[N];
    logic [DW+1:0] q[$];

    always #5 clk = ~clk;

    stdcore_rrarb #(.N(N), .DW(DW), .BURST(B)) dut (
        .clk(clk), .rst(rst), .p(p), .p_val(p_val), .p_rdy(p_rdy),
        .c(c), .c_val(c_val), .c_rdy(c_rdy), .c_id(c_id)
    );
    stdcore_rrarb #(.N(N), .DW(DW), .BURST(1)) dut1 (
        .clk(clk), .rst(rst), .p(p), .p_val(p_val), .p_rdy(p_rdy1),
        .c(c1), .c_val(c_val1), .c_rdy(c_rdy), .c_id(c_id1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    function automatic int pick(input logic [N-1:0] v, input int from);
        for (int i = 0; i < N; i++) if (v[(from + i) % N]) return (from + i) % N;
        return -1;
    endfunction

    // Predicts outputs from the round-robin rules, then advances to the next cycle.
    task automatic model_cycle();
        int own;
        logic ev;
        logic [N-1:0] er;
        own = holder >= 0 ? holder : pick(p_val, nxt);
        ev = !rst && (holder >= 0 ? p_val[holder] : p_val != 0);
        er = (rst || own < 0 || !c_rdy) ? '0 : N'(1) << own;
        check("c_val", c_val, ev);
        check("p_rdy", p_rdy & p_val, er & p_val);
        if (ev) begin
            check("c_id", c_id, own);
            check("c", c, p[own*DW +: DW]);
        end
        if (rst) begin
            holder = -1;
            nxt = 0;
        end else if (holder < 0) begin
            if (own >= 0) begin
                if (B == 1 && c_rdy) nxt = (own + 1) % N;
                else begin
                    holder = own;
                    taken = c_rdy ? 1 : 0;
                end
            end
        end else if (!p_val[holder]) begin
            nxt = (holder + 1) % N;
            holder = -1;
        end else if (c_rdy) begin
            taken++;
            if (taken == B) begin
                nxt = (holder + 1) % N;
                holder = -1;
            end
        end
    endtask

    initial begin
        p = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        #2;
        check("rst_c_val", c_val, 1'b0);
        check("rst_p_rdy", p_rdy, 4'b0000);
`ifndef STDCORE_RRARB_OREG_EN
        p_val = 4'b1111;
        c_rdy = 1'b1;
        do_reset();
        for (int i = 0; i < 17; i++) begin
            #2;
            check("rr_id", c_id, (i / 4) % 4);
            check("rr_c", c, 8'hA0 + (i / 4) % 4);
            check("rr_val", c_val, 1'b1);
            tick();
        end
        p_val = 4'b0100;
        p[23:16] = 8'h5A;
        c_rdy = 1'b0;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            #2;
            check("bp_c", c, 8'h5A);
            check("bp_id", c_id, 2);
            check("bp_val", c_val, 1'b1);
            tick();
            p_val = 4'b0101;
        end
        c_rdy = 1'b1;
        #2;
        check("bp_rdy", p_rdy, 4'b0100);
        tick();
        p_val = 4'b0001;
        #2;
        check("bp_drop_val", c_val, 1'b0);
        tick();
        #2;
        check("bp_next_id", c_id, 0);
        check("bp_next_val", c_val, 1'b1);
        p_val = 4'b0010;
        do_reset();
        #2;
        check("drop_id0", c_id, 1);
        tick();
        p_val = 4'b1011;
        #2;
        check("drop_id1", c_id, 1);
        tick();
        p_val = 4'b1001;
        #2;
        check("drop_gap", c_val, 1'b0);
        tick();
        #2;
        check("drop_next", c_id, 3);
        check("drop_next_val", c_val, 1'b1);
        p_val = 4'b0100;
        do_reset();
        #2;
        check("b1_first", c_id1, 2);
        tick();
        p_val = 4'b1001;
        for (int i = 0; i < 4; i++) begin
            #2;
            check("b1_alt", c_id1, (i % 2) ? 0 : 3);
            check("b1_val", c_val1, 1'b1);
            tick();
        end
        p_val = 4'b0100;
        do_reset();
        tick();
        tick();
        rst = 1'b1;
        p_val = 4'b1111;
        #2;
        check("mid_rst_rdy", p_rdy, 4'b0000);
        check("mid_rst_val", c_val, 1'b0);
        tick();
        rst = 1'b0;
        #2;
        check("post_rst_id", c_id, 0);
        check("post_rst_val", c_val, 1'b1);
`endif
        p_val = '0;
        c_rdy = 1'b0;
        do_reset();
        holder = -1;
        taken = 0;
        nxt = 0;
        for (int k = 0; k < N; k++) sent[k] = 0;
        for (int t = 0; t < 3000; t++) begin
            for (int k = 0; k < N; k++) p[k*DW +: DW] = {2'(k), 6'(sent[k])};
            p_val = 4'($urandom_range(0, 15));
            c_rdy = $urandom_range(0, 9) < 3;
`ifndef STDCORE_RRARB_OREG_EN
            rst = $urandom_range(0, 199) == 0;
            #2;
            model_cycle();
`else
            #2;
            check("oreg_val", c_val, q.size() != 0);
            if (c_val && c_rdy) begin
                if (q.size() == 0) check("oreg_spurious", 1, 0);
                else check("oreg_beat", {c_id, c}, q.pop_front());
            end
            for (int k = 0; k < N; k++)
                if (p_val[k] && p_rdy[k]) q.push_back({2'(k), p[k*DW +: DW]});
`endif
            for (int k = 0; k < N; k++) if (!rst && p_val[k] && p_rdy[k]) sent[k]++;
            tick();
        end
        rst = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
